sdram_arbiter: RTL and testbench

Shares the single SDRAM command/address/data bus between the init, auto-refresh, write and read sequencers.
- Holds the bus for init until init_end.
- Afterwards grants one sequencer at a time. Auto-refresh has highest priority; write and read alternate when both are pending.
- Registers the muxed command/ba/addr/dq toward the SDRAM pins.
- A watchdog recovers the bus from a sequencer that never signals end.

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/sdram_bus_mux.sv | 80 ++++++++
 rtl/sdram_op.v | 12 +
 rtl/sdram_arbiter.sv | 155 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared arbiter types and idle-bus constants.
//   state_t   : arbiter FSM state, also the bus-mux select
//   BA_IDLE   : bank value driven while nobody owns the bus
//   ADDR_IDLE : address value driven while nobody owns the bus
//   CMD_NOP   : command driven while nobody owns the bus
`include "sdram_op.v"

package sdram_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam logic [1:0]  BA_IDLE   = 2'b11;
    localparam logic [12:0] ADDR_IDLE = 13'h1fff;
    localparam logic [3:0]  CMD_NOP   = `OP_NOP;

endpackage

// File: rtl/sdram_bus_mux.sv
// Registered selector of the SDRAM pin bus.
// The source is chosen by the arbiter's current state, so every pin lags the
// selected sequencer's output by exactly one clock.
//   clk, rst          : clock, synchronous active-high reset
//   sel               : current arbiter state
//   init_* / aref_* / wr_* / rd_* : per-sequencer cmd/ba/addr (+ write data)
//   sdram_*           : registered pin outputs
module sdram_bus_mux
    import sdram_pkg::*;
#(
    parameter int DQ_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  state_t          sel,
    input  logic [3:0]      init_cmd,
    input  logic [1:0]      init_ba,
    input  logic [12:0]     init_addr,
    input  logic [3:0]      aref_cmd,
    input  logic [1:0]      aref_ba,
    input  logic [12:0]     aref_addr,
    input  logic [3:0]      wr_cmd,
    input  logic [1:0]      wr_ba,
    input  logic [12:0]     wr_addr,
    input  logic [DQ_W-1:0] wr_dq,
    input  logic            wr_dq_oe,
    input  logic [3:0]      rd_cmd,
    input  logic [1:0]      rd_ba,
    input  logic [12:0]     rd_addr,
    output logic [3:0]      sdram_cmd,
    output logic [1:0]      sdram_ba,
    output logic [12:0]     sdram_addr,
    output logic [DQ_W-1:0] sdram_dq_out,
    output logic            sdram_dq_oe
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_cmd    <= CMD_NOP;
            sdram_ba     <= BA_IDLE;
            sdram_addr   <= ADDR_IDLE;
            sdram_dq_out <= '0;
            sdram_dq_oe  <= 1'b0;
        end else begin
            // Data is only driven during a write grant; elsewhere it is parked at 0.
            sdram_dq_out <= '0;
            sdram_dq_oe  <= 1'b0;
            case (sel)
                ST_INIT: begin
                    sdram_cmd  <= init_cmd;
                    sdram_ba   <= init_ba;
                    sdram_addr <= init_addr;
                end
                ST_AREF: begin
                    sdram_cmd  <= aref_cmd;
                    sdram_ba   <= aref_ba;
                    sdram_addr <= aref_addr;
                end
                ST_WRITE: begin
                    sdram_cmd    <= wr_cmd;
                    sdram_ba     <= wr_ba;
                    sdram_addr   <= wr_addr;
                    sdram_dq_out <= wr_dq;
                    sdram_dq_oe  <= wr_dq_oe;
                end
                ST_READ: begin
                    sdram_cmd  <= rd_cmd;
                    sdram_ba   <= rd_ba;
                    sdram_addr <= rd_addr;
                end
                default: begin
                    sdram_cmd  <= CMD_NOP;
                    sdram_ba   <= BA_IDLE;
                    sdram_addr <= ADDR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sdram_op.v
// SDRAM command encodings shared by every sequencer and the arbiter.
// Commands are {cs_n, ras_n, cas_n, we_n}.
`ifndef SDRAM_OP_V
`define SDRAM_OP_V
`define OP_NOP       4'b0111
`define OP_PRECHARGE 4'b0010
`define OP_AUTO_REF  4'b0001
`define OP_ACTIVE    4'b0011
`define OP_WRITE     4'b0100
`define OP_READ      4'b0101
`define OP_MODE_REG  4'b0000
`endif

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: holds the bus for init, then grants refresh, write and
// read one at a time (refresh first, write/read alternating), with a watchdog
// that takes the bus back from a sequencer that never reports done.
//   clk, rst                 : clock, synchronous active-high reset
//   init_end / init_*        : init sequencer done level and its bus
//   aref_req/aref_end/aref_* : refresh request, done pulse, bus; aref_en grant pulse
//   wr_req/wr_end/wr_*       : write request, done pulse, bus + data; wr_en grant pulse
//   rd_req/rd_end/rd_*       : read request, done pulse, bus; rd_en grant pulse
//   sdram_*                  : registered SDRAM pins
//   grant_err                : one-cycle pulse when the watchdog aborts a grant
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_INIT  | init sequencer owns the bus until init_end
// ST_IDLE  | bus parked at NOP; picks the next grant
// ST_AREF  | auto-refresh owns the bus until aref_end or watchdog
// ST_WRITE | write sequencer owns the bus until wr_end or watchdog
// ST_READ  | read sequencer owns the bus until rd_end or watchdog
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int DQ_W      = 16,
    parameter int GRANT_MAX = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_end,
    input  logic [3:0]      init_cmd,
    input  logic [1:0]      init_ba,
    input  logic [12:0]     init_addr,
    input  logic            aref_req,
    input  logic            aref_end,
    input  logic [3:0]      aref_cmd,
    input  logic [1:0]      aref_ba,
    input  logic [12:0]     aref_addr,
    output logic            aref_en,
    input  logic            wr_req,
    input  logic            wr_end,
    input  logic [3:0]      wr_cmd,
    input  logic [1:0]      wr_ba,
    input  logic [12:0]     wr_addr,
    input  logic [DQ_W-1:0] wr_dq,
    input  logic            wr_dq_oe,
    output logic            wr_en,
    input  logic            rd_req,
    input  logic            rd_end,
    input  logic [3:0]      rd_cmd,
    input  logic [1:0]      rd_ba,
    input  logic [12:0]     rd_addr,
    output logic            rd_en,
    output logic [3:0]      sdram_cmd,
    output logic [1:0]      sdram_ba,
    output logic [12:0]     sdram_addr,
    output logic [DQ_W-1:0] sdram_dq_out,
    output logic            sdram_dq_oe,
    output logic            grant_err
);

    localparam int              WD_W   = $clog2(GRANT_MAX + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(GRANT_MAX);

    state_t          state;
    logic            rr_wr_next;
    logic [WD_W-1:0] watchdog;
    logic            owner_end;

    // Only the current owner's done pulse can end a grant.
    always_comb begin
        owner_end = 1'b0;
        case (state)
            ST_AREF:  owner_end = aref_end;
            ST_WRITE: owner_end = wr_end;
            ST_READ:  owner_end = rd_end;
            default:  owner_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            rr_wr_next <= 1'b1;
            watchdog   <= '0;
            aref_en    <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            grant_err  <= 1'b0;
        end else begin
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            grant_err <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (init_end)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    watchdog <= '0;
                    if (aref_req) begin
                        state   <= ST_AREF;
                        aref_en <= 1'b1;
                    end else if (wr_req && (!rd_req || rr_wr_next)) begin
                        state      <= ST_WRITE;
                        wr_en      <= 1'b1;
                        rr_wr_next <= 1'b0;
                    end else if (rd_req) begin
                        state      <= ST_READ;
                        rd_en      <= 1'b1;
                        rr_wr_next <= 1'b1;
                    end
                end
                ST_AREF, ST_WRITE, ST_READ: begin
                    // A done pulse in the abort cycle still counts as a clean finish.
                    if (owner_end) begin
                        state    <= ST_IDLE;
                        watchdog <= '0;
                    end else if (watchdog == WD_MAX) begin
                        state     <= ST_IDLE;
                        grant_err <= 1'b1;
                        watchdog  <= '0;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sdram_bus_mux #(.DQ_W(DQ_W)) u_bus_mux (
        .clk          (clk),
        .rst          (rst),
        .sel          (state),
        .init_cmd     (init_cmd),
        .init_ba      (init_ba),
        .init_addr    (init_addr),
        .aref_cmd     (aref_cmd),
        .aref_ba      (aref_ba),
        .aref_addr    (aref_addr),
        .wr_cmd       (wr_cmd),
        .wr_ba        (wr_ba),
        .wr_addr      (wr_addr),
        .wr_dq        (wr_dq),
        .wr_dq_oe     (wr_dq_oe),
        .rd_cmd       (rd_cmd),
        .rd_ba        (rd_ba),
        .rd_addr      (rd_addr),
        .sdram_cmd    (sdram_cmd),
        .sdram_ba     (sdram_ba),
        .sdram_addr   (sdram_addr),
        .sdram_dq_out (sdram_dq_out),
        .sdram_dq_oe  (sdram_dq_oe)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios followed by a randomized phase,
// every cycle compared against a bus-ownership reference model.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int DQ_W      = 16;
    localparam int GRANT_MAX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            init_end = 1'b0;
    logic [3:0]      init_cmd = 4'b0111;
    logic [1:0]      init_ba = 2'b11;
    logic [12:0]     init_addr = 13'h1fff;
    logic            aref_req = 1'b0, aref_end = 1'b0;
    logic [3:0]      aref_cmd = 4'b0111;
    logic [1:0]      aref_ba = 2'b00;
    logic [12:0]     aref_addr = 13'h0;
    logic            wr_req = 1'b0, wr_end = 1'b0;
    logic [3:0]      wr_cmd = 4'b0111;
    logic [1:0]      wr_ba = 2'b00;
    logic [12:0]     wr_addr = 13'h0;
    logic [DQ_W-1:0] wr_dq = '0;
    logic            wr_dq_oe = 1'b0;
    logic            rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]      rd_cmd = 4'b0111;
    logic [1:0]      rd_ba = 2'b00;
    logic [12:0]     rd_addr = 13'h0;
    logic            aref_en, wr_en, rd_en, grant_err, sdram_dq_oe;
    logic [3:0]      sdram_cmd;
    logic [1:0]      sdram_ba;
    logic [12:0]     sdram_addr;
    logic [DQ_W-1:0] sdram_dq_out;

    sdram_arbiter #(.DQ_W(DQ_W), .GRANT_MAX(GRANT_MAX)) dut (
        .clk(clk), .rst(rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
        .aref_addr(aref_addr), .aref_en(aref_en),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe), .wr_en(wr_en),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .grant_err(grant_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the bus, how long it has held it, and who is preferred next.
    typedef enum {OWN_INIT, OWN_NONE, OWN_AREF, OWN_WR, OWN_RD} own_t;
    own_t            m_owner = OWN_INIT;
    bit              m_prefer_wr = 1'b1;
    int              m_held = 0;
    logic            e_aref_en = 0, e_wr_en = 0, e_rd_en = 0, e_err = 0, e_oe = 0;
    logic [3:0]      e_cmd = 4'b0111;
    logic [1:0]      e_ba = 2'b11;
    logic [12:0]     e_addr = 13'h1fff;
    logic [DQ_W-1:0] e_dq = '0;

    // Sequencer emulation controls
    int  lat_aref = 0, lat_wr = 0, lat_rd = 0;
    int  cnt_a = 0, cnt_w = 0, cnt_r = 0;
    bit  rand_mode = 0, auto_drop = 0, force_oe = 0;
    int  n_err_obs = 0;
    int  gq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit fin;
        e_aref_en = 0; e_wr_en = 0; e_rd_en = 0; e_err = 0;
        if (rst) begin
            m_owner = OWN_INIT; m_prefer_wr = 1; m_held = 0;
            e_cmd = 4'b0111; e_ba = 2'b11; e_addr = 13'h1fff; e_dq = '0; e_oe = 0;
            return;
        end
        e_dq = '0; e_oe = 0;
        case (m_owner)
            OWN_INIT: begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
            OWN_AREF: begin e_cmd = aref_cmd; e_ba = aref_ba; e_addr = aref_addr; end
            OWN_WR:   begin e_cmd = wr_cmd; e_ba = wr_ba; e_addr = wr_addr; e_dq = wr_dq; e_oe = wr_dq_oe; end
            OWN_RD:   begin e_cmd = rd_cmd; e_ba = rd_ba; e_addr = rd_addr; end
            default:  begin e_cmd = 4'b0111; e_ba = 2'b11; e_addr = 13'h1fff; end
        endcase
        case (m_owner)
            OWN_INIT: if (init_end) m_owner = OWN_NONE;
            OWN_NONE: begin
                m_held = 0;
                if (aref_req) begin
                    m_owner = OWN_AREF; e_aref_en = 1;
                end else if (wr_req && (m_prefer_wr || !rd_req)) begin
                    m_owner = OWN_WR; e_wr_en = 1; m_prefer_wr = 0;
                end else if (rd_req) begin
                    m_owner = OWN_RD; e_rd_en = 1; m_prefer_wr = 1;
                end
            end
            default: begin
                fin = (m_owner == OWN_AREF && aref_end) || (m_owner == OWN_WR && wr_end) ||
                      (m_owner == OWN_RD && rd_end);
                if (fin) m_owner = OWN_NONE;
                else if (m_held == GRANT_MAX) begin m_owner = OWN_NONE; e_err = 1; end
                else m_held++;
            end
        endcase
    endtask

    task automatic emu(inout int cnt, input int lat, input logic en, output logic e);
        e = 1'b0;
        if (cnt > 0) begin
            cnt--;
            e = (cnt == 0);
        end
        if (en && lat > 0) cnt = lat;
    endtask

    task automatic tick();
        logic ea, ew, er;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("aref_en", aref_en, e_aref_en);
        chk("wr_en", wr_en, e_wr_en);
        chk("rd_en", rd_en, e_rd_en);
        chk("grant_err", grant_err, e_err);
        chk("sdram_cmd", sdram_cmd, e_cmd);
        chk("sdram_ba", sdram_ba, e_ba);
        chk("sdram_addr", sdram_addr, e_addr);
        chk("sdram_dq_out", sdram_dq_out, e_dq);
        chk("sdram_dq_oe", sdram_dq_oe, e_oe);
        if (grant_err === 1'b1) n_err_obs++;
        if (aref_en === 1'b1) gq.push_back(1);
        if (wr_en === 1'b1) gq.push_back(2);
        if (rd_en === 1'b1) gq.push_back(3);
        // new payloads every cycle
        aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = 13'($urandom);
        wr_cmd = 4'($urandom); wr_ba = 2'($urandom); wr_addr = 13'($urandom);
        wr_dq = DQ_W'($urandom); wr_dq_oe = force_oe ? 1'b1 : 1'($urandom);
        rd_cmd = 4'($urandom); rd_ba = 2'($urandom); rd_addr = 13'($urandom);
        if (rand_mode) begin
            init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = 13'($urandom);
            aref_end = ($urandom_range(4) == 0);
            wr_end   = ($urandom_range(4) == 0);
            rd_end   = ($urandom_range(4) == 0);
        end else begin
            emu(cnt_a, lat_aref, e_aref_en, ea); aref_end = ea;
            emu(cnt_w, lat_wr, e_wr_en, ew);     wr_end = ew;
            emu(cnt_r, lat_rd, e_rd_en, er);     rd_end = er;
            if (auto_drop) begin
                if (e_aref_en) aref_req = 1'b0;
                if (e_wr_en)   wr_req = 1'b0;
                if (e_rd_en)   rd_req = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(); tick();
        chk("rst_state", dut.state, 32'(ST_INIT));
        chk("rst_rr_wr_next", dut.rr_wr_next, 1);

        // Init ownership and hand-off
        rst = 1'b0; init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
        tick();
        chk("init_cmd_passthru", sdram_cmd, 4'b0010);
        tick();
        init_end = 1'b1;
        tick();
        chk("init_exit_state", dut.state, 32'(ST_IDLE));
        tick();
        chk("idle_nop", sdram_cmd, 4'b0111);

        // All three requests at once: refresh, then write, then read
        gq.delete();
        lat_aref = 3; lat_wr = 4; lat_rd = 4; auto_drop = 1;
        aref_req = 1; wr_req = 1; rd_req = 1;
        repeat (22) tick();
        chk("prio_count", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("prio_first_aref", gq[0], 1);
            chk("prio_second_wr", gq[1], 2);
            chk("prio_third_rd", gq[2], 3);
        end

        // Write/read both pending continuously: alternation
        gq.delete();
        auto_drop = 0; lat_wr = 5; lat_rd = 5;
        wr_req = 1; rd_req = 1;
        repeat (30) tick();
        wr_req = 0; rd_req = 0;
        repeat (8) tick();
        chk("rr_enough_grants", 32'(gq.size() >= 4), 1);
        if (gq.size() > 0) chk("rr_first_wr", gq[0], 2);
        for (int i = 1; i < gq.size(); i++)
            chk("rr_alternate", 32'(gq[i] != gq[i-1]), 1);

        // Refresh request during a write waits for wr_end
        gq.delete();
        auto_drop = 1; lat_wr = 6; lat_aref = 2;
        wr_req = 1;
        tick(); tick(); tick();
        aref_req = 1;
        repeat (14) tick();
        chk("no_preempt_count", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("no_preempt_wr_first", gq[0], 2);
            chk("no_preempt_aref_after", gq[1], 1);
        end

        // Watchdog abort on a read that never ends
        n_err_obs = 0; lat_rd = 0; rd_req = 1;
        repeat (16) tick();
        chk("wd_abort_count", n_err_obs, 1);

        // Done pulse exactly on the abort cycle wins
        n_err_obs = 0; lat_rd = GRANT_MAX; rd_req = 1;
        repeat (16) tick();
        chk("wd_end_wins", n_err_obs, 0);

        // Reset in the middle of a write
        force_oe = 1; lat_wr = 0; wr_req = 1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_state", dut.state, 32'(ST_INIT));
        chk("rst_mid_rr", dut.rr_wr_next, 1);
        chk("rst_mid_oe", sdram_dq_oe, 0);
        chk("rst_mid_cmd", sdram_cmd, 4'b0111);
        rst = 1'b0; force_oe = 0; wr_req = 0; cnt_a = 0; cnt_w = 0; cnt_r = 0;

        // Randomized traffic
        rand_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(199) == 0);
            init_end = ($urandom_range(3) == 0);
            if ($urandom_range(5) == 0) aref_req = ~aref_req;
            wr_req = ($urandom_range(1) == 0);
            rd_req = ($urandom_range(1) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
